// File: rtl/instr_mem_pkg.sv
// Shared constants, FSM encoding and instruction-field helpers for the instruction memory.
package instr_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 2048;

    localparam int unsigned OPC_W = 5;
    localparam int unsigned OPD_W = DATA_W_DEF - OPC_W;

    localparam logic [OPC_W-1:0] HLT_OPCODE = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Opcode occupies the top bits of an instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W_DEF-1:0] word);
        return word[DATA_W_DEF-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/instr_ram.sv
// Single-port synchronous RAM; one port shared by program-load writes and fetch reads.
module instr_ram #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array is never reset so the tools map it onto block RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register holds its value whenever no read is enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory with a program loader: holds the CPU while a program streams in, then serves fetches.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Instr,
    output logic              InstrValid,
    output logic              CpuHold,
    input  logic              LoadStart,
    input  logic [DATA_W-1:0] LoadData,
    input  logic              LoadValid,
    input  logic              LoadLast,
    output logic              LoadReady
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              beat_c;
    logic              ram_en_c;
    logic              ram_we_c;
    logic [ADDR_W-1:0] ram_addr_c;

    // Next-state and load-pointer logic; the pointer saturates at the last word.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        beat_c     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (LoadStart) begin
                    state_next = ST_LOAD;
                    ptr_next   = '0;
                end
            end
            ST_LOAD: begin
                if (LoadValid) begin
                    beat_c = 1'b1;
                    if (ptr != PTR_LAST) begin
                        ptr_next = ptr + ADDR_W'(1);
                    end
                    if (LoadLast || (ptr == PTR_LAST)) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (LoadStart) begin
                    state_next = ST_LOAD;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            CpuHold    <= 1'b1;
            LoadReady  <= 1'b0;
            InstrValid <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            CpuHold    <= (state_next != ST_RUN);
            LoadReady  <= (state_next == ST_LOAD);
            InstrValid <= (state == ST_RUN) && (state_next == ST_RUN);
        end
    end

    assign ram_we_c   = Reset && beat_c;
    assign ram_en_c   = ram_we_c || (state == ST_RUN);
    assign ram_addr_c = (state == ST_LOAD) ? ptr : Addr;

    instr_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (Clk),
        .rst_n (Reset),
        .en    (ram_en_c),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (LoadData),
        .rdata (Instr)
    );

endmodule
